// File: rtl/demuxn_stream.sv
// demuxn_stream: routes one valid/ready input stream to one of N output lanes
// by a select field. Each lane has its own 2-entry FIFO. Beats whose select
// is out of range are always accepted, then discarded and counted.
module demuxn_stream #(
  parameter int unsigned N     = 2,
  parameter int unsigned width = 2,
  localparam int unsigned SW   = (N > 2) ? $clog2(N) : 1
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [width-1:0] I_data,
  input  logic [SW-1:0]    I_sel,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [width-1:0] O_data [N],
  output logic [N-1:0]     O_valid,
  input  logic [N-1:0]     O_ready,
  output logic [7:0]       drop_count
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;
  localparam int unsigned DCW   = 8;

  logic [CW-1:0]    cnt    [N];
  logic [N-1:0]     rd_ptr;
  logic [N-1:0]     wr_ptr;
  logic [width-1:0] mem    [N][DEPTH];

  logic             sel_ok_c;
  logic [SW-1:0]    sel_idx_c;
  logic [N-1:0]     push_c;
  logic [N-1:0]     pop_c;
  logic             drop_c;

  // Input handshake: ready depends only on registered lane occupancy and I_sel.
  // An out-of-range select is steered to lane 0 for the lookup, then ignored.
  always_comb begin
    sel_ok_c  = (32'(I_sel) < N);
    sel_idx_c = sel_ok_c ? I_sel : '0;
    I_ready   = !sel_ok_c || (cnt[sel_idx_c] != CW'(DEPTH));
    drop_c    = I_valid && !sel_ok_c;
    push_c    = '0;
    pop_c     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      push_c[k] = I_valid && sel_ok_c && I_ready && (I_sel == SW'(k));
      pop_c[k]  = O_valid[k] && O_ready[k];
    end
  end

  // Lane outputs: valid while occupied, data is the entry under the read pointer.
  always_comb begin
    O_valid = '0;
    for (int unsigned k = 0; k < N; k++) begin
      O_valid[k] = (cnt[k] != '0);
      O_data[k]  = mem[k][rd_ptr[k]];
    end
  end

  // Per-lane occupancy and pointers; a simultaneous push and pop keeps cnt.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (push_c[k]) begin
          wr_ptr[k] <= ~wr_ptr[k];
        end
        if (pop_c[k]) begin
          rd_ptr[k] <= ~rd_ptr[k];
        end
        if (push_c[k] && !pop_c[k]) begin
          cnt[k] <= cnt[k] + CW'(1);
        end else if (!push_c[k] && pop_c[k]) begin
          cnt[k] <= cnt[k] - CW'(1);
        end
      end
    end
  end

  // Lane storage; contents are never cleared, occupancy alone decides validity.
  always_ff @(posedge CLK) begin
    for (int unsigned k = 0; k < N; k++) begin
      if (push_c[k]) begin
        mem[k][wr_ptr[k]] <= I_data;
      end
    end
  end

  // Saturating count of beats discarded for an out-of-range select.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      drop_count <= '0;
    end else if (drop_c && (drop_count != {DCW{1'b1}})) begin
      drop_count <= drop_count + DCW'(1);
    end
  end

endmodule

// File: doc/demuxn_stream.md
# demuxn_stream

Stream demultiplexer with valid/ready handshaking: one input stream carrying a select field is routed to one of N output lanes. Each lane has a 2-entry buffer, so input ready depends only on registered state. Beats whose select is out of range are consumed and counted. It is the inverse of the muxn/Mux2xBits path and feeds per-lane consumers downstream of a shared producer.

## Interface

- `N`, default 2, number of output lanes (2..16).
- `width`, default 2, data bits per beat (≥1).
- `SW`, derived as max(1, clog2(N)), select width; not overridable.

- `CLK`  in  1  clock; all state updates on the rising edge.
- `ASYNCRESETN`  in  1  reset, asynchronous, active-low.
- `I_data`  in  width  input beat data.
- `I_sel`  in  SW  destination lane for the beat.
- `I_valid`  in  1  input beat present.
- `I_ready`  out  1  input beat accepted this cycle when high with I_valid.
- `O_data`  out  [width-1:0] × N (unpacked array)  head data of each lane.
- `O_valid`  out  N  lane k head valid.
- `O_ready`  in  N  lane k consumer accepts head.
- `drop_count`  out  8  saturating count of out-of-range beats.

## Operation

- Per lane k: 2-entry FIFO with `cnt[k]` in 0..2, read/write pointers, and storage. `O_valid[k] = (cnt[k] != 0)`. `O_data[k]` = head entry, or don't-care when empty.
- Push is `I_valid & I_ready & (I_sel < N)`. It writes lane I_sel only.
- Pop k is `O_valid[k] & O_ready[k]`. Lanes pop independently; several may pop in the same cycle.
- `I_ready`:
  - If `I_sel >= N`, it is 1 and the beat is dropped.
  - Otherwise it is `cnt[I_sel] < 2`, a function of registered state and I_sel only. No combinational path from O_ready.
- `I_ready` is driven even when I_valid=0. The producer must hold I_data and I_sel stable while I_valid is high and ready is low.
- Simultaneous push and pop on the same lane:
  - cnt unchanged.
  - At cnt=1, the new beat becomes head next cycle.
  - At cnt=2, push cannot occur because ready=0.
- Order is strictly FIFO within a lane. There is no ordering guarantee across lanes.
- Drop: when `I_valid & I_sel >= N`, `drop_count` increments and saturates at 255. This can only occur when N is not a power of two.
- Reset (asserted asynchronously, any cycle):
  - All cnt=0, all pointers=0, drop_count=0.
  - O_valid=0 immediately.
  - I_ready after reset is 1 for every I_sel.
  - Storage contents are not reset.
- Reset during operation discards all buffered beats. No partial beat is ever presented.

## Timing

- Latency: a beat accepted at edge t is visible with O_valid=1 after edge t, one cycle, when the lane was empty.
- Throughput: 1 beat/cycle into a lane whose consumer holds O_ready=1 continuously. 1 beat/cycle aggregate across lanes.
- A full lane (cnt=2) re-raises I_ready for that select in the cycle after its pop edge.
- Head-of-line: a stalled beat to a full lane blocks the input. This is required, with no reordering.
- Deassertion of ASYNCRESETN is assumed synchronized externally. The first push can occur at the first edge after deassertion.

## Test plan

- **Reset:** hold ASYNCRESETN=0 with I_valid=1, then release -> O_valid=0 and drop_count=0 during reset. Beat accepted at the first edge after release.
- **Single routing (N=4, width=8):** send 0xA5 to sel=2 with all O_ready=0.
  - O_valid=4'b0100 and O_data[2]=0xA5 one cycle later.
  - Other lanes stay invalid.
- **Backpressure (N=2):**
  - Send 0x1, 0x2, 0x3 to lane 1 with O_ready[1]=0 -> I_ready drops after 2 accepts.
  - Raise O_ready[1] -> lane 1 outputs 1, 2, 3 in order, and 0x3 is accepted the cycle after the first pop.
- **Concurrent push/pop:** lane 0 at cnt=1 with O_ready[0]=1 while pushing to lane 0 every cycle -> sustained 1 beat/cycle, cnt stays 1, data in order.
- **Drop (N=3):**
  - 300 beats with sel=3 -> I_ready=1 throughout, no O_valid, drop_count=255.
  - A following sel=0 beat is routed normally.
- **Mid-operation reset:** lanes 0 and 1 at cnt=2, assert ASYNCRESETN=0 between edges -> O_valid=0 immediately. After release, the old data never reappears.
